// File: rtl/arb_requester.sv
`default_nettype none
// ============================================================================
// Module   : arb_requester
// Purpose  : Client-side agent for one slot of a two-way round-robin
//            arbiter. Issues one bus beat per granted cycle for each burst.
// Revision : 1.0 - initial release
// ============================================================================
module arb_requester #(
  parameter int ADDR_W  = 8,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              req,
  input  logic              grant,
  output logic              bus_valid,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_last,
  output logic              done,
  output logic              err_stray,
  output logic              err_starve
);

  localparam logic [0:0] c_ST_IDLE  = 1'b0;
  localparam logic [0:0] c_ST_BURST = 1'b1;

  localparam int                c_WAIT_W     = $clog2(TIMEOUT + 1);
  localparam logic [c_WAIT_W-1:0] c_TIMEOUT    = c_WAIT_W'(TIMEOUT);
  localparam logic [c_WAIT_W-1:0] c_TIMEOUT_M1 = c_WAIT_W'(TIMEOUT - 1);

  logic [0:0]          r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_rem;
  logic [c_WAIT_W-1:0] r_wait;
  logic                r_done;
  logic                r_err_stray;
  logic                r_err_starve;

  logic w_in_burst;
  logic w_rem_zero;

  assign w_in_burst = (r_state == c_ST_BURST);
  assign w_rem_zero = (r_rem == '0);

  // req falls combinationally on the final beat so the arbiter's next grant is 0
  assign cmd_ready  = ~w_in_burst;
  assign bus_valid  = w_in_burst & grant;
  assign bus_last   = bus_valid & w_rem_zero;
  assign req        = w_in_burst & ~bus_last;
  assign bus_addr   = r_addr;
  assign done       = r_done;
  assign err_stray  = r_err_stray;
  assign err_starve = r_err_starve;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= c_ST_IDLE;
      r_addr       <= '0;
      r_rem        <= '0;
      r_wait       <= '0;
      r_done       <= 1'b0;
      r_err_stray  <= 1'b0;
      r_err_starve <= 1'b0;
    end else begin
      r_done <= bus_last;
      if (grant && !w_in_burst) begin
        r_err_stray <= 1'b1;
      end
      if (!w_in_burst) begin
        r_wait <= '0;
        if (cmd_valid) begin
          r_state <= c_ST_BURST;
          r_addr  <= cmd_addr;
          r_rem   <= cmd_len;
        end
      end else if (grant) begin
        r_wait <= '0;
        if (w_rem_zero) begin
          r_state <= c_ST_IDLE;
        end else begin
          r_addr <= r_addr + 1'b1;
          r_rem  <= r_rem - 1'b1;
        end
      end else begin
        // Waiting for grant: count up to the saturation point, flag on arrival
        if (r_wait != c_TIMEOUT) begin
          r_wait <= r_wait + 1'b1;
        end
        if (r_wait == c_TIMEOUT_M1) begin
          r_err_starve <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arb_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb_requester
// Purpose  : Directed self-checking bench: two requesters on a round-robin
//            arbiter model, or with grants driven directly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arb_requester;

  logic       clk;
  logic       reset;
  logic       use_arb;
  logic       cv0, cv1, g0, g1;
  logic [3:0] len0, len1;
  logic [7:0] addr0, addr1;

  logic       rdy0, rdy1, req0, req1, bv0, bv1, bl0, bl1;
  logic       done0, done1, es0, es1, ev0, ev1;
  logic [7:0] ba0, ba1;
  logic       grant0, grant1;
  logic [1:0] arb_g;
  logic       arb_last;

  int errors = 0;
  int checks = 0;

  assign grant0 = use_arb ? arb_g[0] : g0;
  assign grant1 = use_arb ? arb_g[1] : g1;

  arb_requester #(.ADDR_W(8), .LEN_W(4), .TIMEOUT(32)) u0 (
    .clk(clk), .reset(reset), .cmd_valid(cv0), .cmd_ready(rdy0),
    .cmd_len(len0), .cmd_addr(addr0), .req(req0), .grant(grant0),
    .bus_valid(bv0), .bus_addr(ba0), .bus_last(bl0), .done(done0),
    .err_stray(es0), .err_starve(ev0)
  );

  arb_requester #(.ADDR_W(8), .LEN_W(4), .TIMEOUT(32)) u1 (
    .clk(clk), .reset(reset), .cmd_valid(cv1), .cmd_ready(rdy1),
    .cmd_len(len1), .cmd_addr(addr1), .req(req1), .grant(grant1),
    .bus_valid(bv1), .bus_addr(ba1), .bus_last(bl1), .done(done1),
    .err_stray(es1), .err_starve(ev1)
  );

  // Registered round-robin arbiter: client 0 wins the first tie after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arb_g    <= 2'b00;
      arb_last <= 1'b1;
    end else if (req0 && req1) begin
      arb_g    <= arb_last ? 2'b01 : 2'b10;
      arb_last <= ~arb_last;
    end else if (req0) begin
      arb_g    <= 2'b01;
      arb_last <= 1'b0;
    end else if (req1) begin
      arb_g    <= 2'b10;
      arb_last <= 1'b1;
    end else begin
      arb_g    <= 2'b00;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int beats, dones, n0, n1, tot, last_owner, last_cyc, bidx;
    logic [7:0] exp_a, exp0, exp1;
    int pat [5];

    reset = 1'b0; use_arb = 1'b1;
    cv0 = 0; cv1 = 0; g0 = 0; g1 = 0;
    len0 = 0; len1 = 0; addr0 = 0; addr1 = 0;
    #2;
    chk("rst_ready", rdy0, 1);
    chk("rst_req", req0, 0);
    chk("rst_valid", bv0, 0);
    chk("rst_done", done0, 0);
    chk("rst_errs", {es0, ev0, es1, ev1}, 0);
    tick();
    reset = 1'b1;

    // Single beat, uncontended
    tick(); cv0 = 1; len0 = 4'd0; addr0 = 8'h10; #1;
    chk("t1_c0_ready", rdy0, 1);
    chk("t1_c0_req", req0, 0);
    tick(); cv0 = 0; #1;
    chk("t1_c1_req", req0, 1);
    chk("t1_c1_valid", bv0, 0);
    tick(); #1;
    chk("t1_c2_valid", bv0, 1);
    chk("t1_c2_last", bl0, 1);
    chk("t1_c2_addr", ba0, 8'h10);
    chk("t1_c2_req", req0, 0);
    tick(); #1;
    chk("t1_c3_done", done0, 1);
    chk("t1_c3_req", req0, 0);
    chk("t1_c3_ready", rdy0, 1);
    tick(); #1;
    chk("t1_c4_done", done0, 0);

    // Full 16-beat burst wrapping the address
    tick(); cv0 = 1; len0 = 4'd15; addr0 = 8'hFC; #1;
    beats = 0; dones = 0; exp_a = 8'hFC;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (c == 1) cv0 = 0;
      #1;
      if (bv0) begin
        if (beats == 0) chk("t2_first_cycle", c, 2);
        chk("t2_addr", ba0, exp_a);
        chk("t2_last", bl0, (beats == 15));
        exp_a = exp_a + 8'd1;
        beats++;
      end
      if (done0) begin
        dones++;
        chk("t2_done_cycle", c, 18);
      end
    end
    chk("t2_beats", beats, 16);
    chk("t2_dones", dones, 1);

    // Contention: both clients issue 4-beat bursts together
    tick(); cv0 = 1; cv1 = 1; len0 = 4'd3; len1 = 4'd3; addr0 = 8'h20; addr1 = 8'h40; #1;
    n0 = 0; n1 = 0; tot = 0; last_owner = -1; last_cyc = -1;
    exp0 = 8'h20; exp1 = 8'h40;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 1) begin cv0 = 0; cv1 = 0; end
      #1;
      chk("t3_both_valid", {bv0, bv1} == 2'b11, 0);
      if (bv0 || bv1) begin
        if (tot > 0) begin
          chk("t3_alternate", bv0 ? 0 : 1, (last_owner == 0) ? 1 : 0);
          chk("t3_contiguous", c, last_cyc + 1);
        end
        if (bv0) begin
          chk("t3_addr0", ba0, exp0);
          exp0 = exp0 + 8'd1; n0++; last_owner = 0;
        end else begin
          chk("t3_addr1", ba1, exp1);
          exp1 = exp1 + 8'd1; n1++; last_owner = 1;
        end
        last_cyc = c;
        tot++;
      end
    end
    chk("t3_n0", n0, 4);
    chk("t3_n1", n1, 4);
    chk("t3_total", tot, 8);
    chk("t3_stray", {es0, es1}, 0);

    // Directed grant pattern 1,0,0,1,1 on a 3-beat burst
    tick(); use_arb = 0; g0 = 0; cv0 = 1; len0 = 4'd2; addr0 = 8'h30; #1;
    tick(); cv0 = 0; #1;
    chk("t4_req_pre", req0, 1);
    chk("t4_valid_pre", bv0, 0);
    pat = '{1, 0, 0, 1, 1};
    bidx = 0;
    for (int i = 0; i < 5; i++) begin
      tick(); g0 = pat[i][0]; #1;
      chk("t4_valid", bv0, pat[i]);
      chk("t4_last", bl0, (i == 4));
      chk("t4_req", req0, (i != 4));
      if (pat[i] == 1) begin
        chk("t4_addr", ba0, 8'h30 + bidx);
        bidx++;
      end
    end
    tick(); g0 = 0; #1;
    chk("t4_done", done0, 1);
    chk("t4_ready", rdy0, 1);

    // Stray grant in IDLE
    tick(); g0 = 1; #1;
    chk("t5_stray_valid", bv0, 0);
    chk("t5_stray_pre", es0, 0);
    tick(); g0 = 0; #1;
    chk("t5_stray_set", es0, 1);
    tick(); tick(); tick();
    chk("t5_stray_sticky", es0, 1);
    chk("t5_stray_other", es1, 0);

    // Starvation on client 1, then grants resume
    tick(); g1 = 0; cv1 = 1; len1 = 4'd1; addr1 = 8'h50; #1;
    for (int c = 1; c <= 35; c++) begin
      tick();
      if (c == 1) cv1 = 0;
      #1;
      if (c == 32) chk("t6_starve_pre", ev1, 0);
      if (c == 33) chk("t6_starve_set", ev1, 1);
      if (c == 35) chk("t6_req_held", req1, 1);
    end
    tick(); g1 = 1; #1;
    chk("t6_b0_valid", bv1, 1);
    chk("t6_b0_addr", ba1, 8'h50);
    chk("t6_b0_last", bl1, 0);
    tick(); #1;
    chk("t6_b1_addr", ba1, 8'h51);
    chk("t6_b1_last", bl1, 1);
    chk("t6_b1_req", req1, 0);
    tick(); g1 = 0; #1;
    chk("t6_done", done1, 1);
    chk("t6_starve_sticky", ev1, 1);

    // Reset in the middle of an 8-beat burst, after two beats
    tick(); g0 = 0; cv0 = 1; len0 = 4'd7; addr0 = 8'h60; #1;
    tick(); cv0 = 0; #1;
    tick(); g0 = 1; #1;
    chk("t7_b0_addr", ba0, 8'h60);
    tick(); #1;
    chk("t7_b1_addr", ba0, 8'h61);
    tick(); reset = 0; #1;
    chk("t7_rst_req", req0, 0);
    chk("t7_rst_valid", bv0, 0);
    chk("t7_rst_done", done0, 0);
    chk("t7_rst_errs", {es0, ev1}, 0);
    tick(); g0 = 0; #1; reset = 1; #1;
    chk("t7_post_ready", rdy0, 1);
    chk("t7_post_req", req0, 0);
    tick(); #1;
    chk("t7_post_done", done0, 0);
    chk("t7_post_errs", {es0, ev0, es1, ev1}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
